wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: single-cycle ALU results and a 2-deep in-order
// queue of long-latency results share one write port, with a starvation guard for the queue.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [1:0]  q_count
);

    localparam int unsigned EntryW = 37;
    typedef logic [EntryW-1:0] entry_t;

    logic [1:0]  count_q, count_d;
    logic [1:0]  starve_q, starve_d;
    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic        q_nonempty_s;
    logic        alu_grant_s;
    logic        q_grant_s;
    logic        push_s;
    logic        slot_s;
    entry_t      grant_entry_s;

    assign q_nonempty_s  = (count_q != 2'd0);
    assign alu_stall     = alu_valid && (starve_q == 2'd3) && q_nonempty_s;
    assign mem_ready     = (count_q != 2'd2);
    assign alu_grant_s   = alu_valid && !alu_stall;
    assign q_grant_s     = !alu_grant_s && q_nonempty_s;
    assign push_s        = mem_valid && mem_ready;
    // A push lands behind whatever survives this cycle's pop.
    assign slot_s        = (count_q == 2'd1) && !q_grant_s;
    assign grant_entry_s = alu_grant_s ? {alu_rd, alu_data} : fifo_q[0];

    assign we      = we_q;
    assign rd_addr = addr_q;
    assign rd_data = data_q;
    assign q_count = count_q;

    // Queue storage and occupancy next state.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        if (q_grant_s) begin
            fifo_d[0] = fifo_q[1];
        end else begin
            fifo_d[0] = fifo_q[0];
        end
        if (push_s) begin
            fifo_d[slot_s] = {mem_rd, mem_data};
        end else begin
            fifo_d[slot_s] = fifo_d[slot_s];
        end
        case ({push_s, q_grant_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts ALU wins over a waiting queue, saturating at 3.
    always_comb begin
        starve_d = starve_q;
        if (!q_nonempty_s || q_grant_s) begin
            starve_d = 2'd0;
        end else if (alu_grant_s && (starve_q != 2'd3)) begin
            starve_d = starve_q + 2'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Write-port next state; x0 is consumed but never written.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (alu_grant_s || q_grant_s) begin
            we_d   = (grant_entry_s[36:32] != 5'd0);
            addr_d = grant_entry_s[36:32];
            data_d = grant_entry_s[31:0];
        end else begin
            we_d   = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 2'd0;
            starve_q  <= 2'd0;
            fifo_q[0] <= {EntryW{1'b0}};
            fifo_q[1] <= {EntryW{1'b0}};
            we_q      <= 1'b0;
            addr_q    <= 5'd0;
            data_q    <= 32'd0;
        end else begin
            count_q   <= count_d;
            starve_q  <= starve_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

endmodule
